jk_bank_arbiter: RTL

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_bank_arbiter_if.sv | 64 ++++++
 rtl/jk_bank_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter_if
//
// Bundles the command bus between two requesters and the JK flop bank.
//
// Parameters
//   N          number of JK flip-flops in the bank
//   IW         flop index width, clog2(N)
//
// Signals
//   req_valid  [1:0]       per-requester command valid (bit r = requester r)
//   req_idx    [2*IW-1:0]  target flop index, requester r owns [IW*r +: IW]
//   req_j      [1:0]       J value per requester
//   req_k      [1:0]       K value per requester
//   req_ready  [1:0]       one-hot grant or zero; accept on valid & ready
//   q          [N-1:0]     bank flop outputs
//   q1         [N-1:0]     complement of q
//   done                   one-cycle pulse after a command has been applied
//   cmd_count  [7:0]       commands applied since reset, wraps at 256
//
// Modports
//   master     requester side (drives the request fields)
//   slave      bank side (drives grant and bank state)
// -----------------------------------------------------------------------------
interface jk_bank_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = 2
);

    logic [1:0]      req_valid;
    logic [2*IW-1:0] req_idx;
    logic [1:0]      req_j;
    logic [1:0]      req_k;
    logic [1:0]      req_ready;
    logic [N-1:0]    q;
    logic [N-1:0]    q1;
    logic            done;
    logic [7:0]      cmd_count;

    modport master (
        output req_valid,
        output req_idx,
        output req_j,
        output req_k,
        input  req_ready,
        input  q,
        input  q1,
        input  done,
        input  cmd_count
    );

    modport slave (
        input  req_valid,
        input  req_idx,
        input  req_j,
        input  req_k,
        output req_ready,
        output q,
        output q1,
        output done,
        output cmd_count
    );

endinterface

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
//
// A bank of N JK flip-flops shared by two requesters. In IDLE the two
// requesters are arbitrated combinationally (round robin on contention); the
// winning command is captured and applied to its flop on the following edge,
// which also pulses done and bumps cmd_count. At most one command every two
// cycles.
//
// Parameters
//   N    number of JK flip-flops (default 4)
//   IW   index width, must equal clog2(N) (default 2)
//
// Ports
//   clk  single clock, all state updates on the rising edge
//   rst  synchronous, active-high reset
//   bus  jk_bank_arbiter_if slave modport:
//          req_valid/req_idx/req_j/req_k in, req_ready/q/q1/done/cmd_count out
// -----------------------------------------------------------------------------
module jk_bank_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic             clk,
    input  logic             rst,
    jk_bank_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          j;
        logic          k;
    } cmd_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t       state;
    cmd_t         cmd;        // command captured at acceptance
    logic         rr_ptr;     // requester favoured when both are valid
    logic [N-1:0] q_reg;
    logic         done_reg;
    logic [7:0]   count_reg;

    // -------------------------------------------------------------------------
    // Arbitration (combinational, only in IDLE and outside reset)
    // -------------------------------------------------------------------------
    logic [1:0] grant;
    logic       winner;
    logic       accept;
    cmd_t       win_cmd;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        grant  = 2'b00;
        winner = 1'b0;
        if (!rst && state == IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    grant  = 2'b01;
                    winner = 1'b0;
                end
                2'b10: begin
                    grant  = 2'b10;
                    winner = 1'b1;
                end
                2'b11: begin
                    winner = rr_ptr;
                    grant  = rr_ptr ? 2'b10 : 2'b01;
                end
                default: begin
                    grant  = 2'b00;
                    winner = 1'b0;
                end
            endcase
        end
    end

    assign accept = |grant;

    // Fields of the winning requester, ready to be captured.
    always_comb begin
        if (winner) begin
            win_cmd.idx = bus.req_idx[2*IW-1:IW];
            win_cmd.j   = bus.req_j[1];
            win_cmd.k   = bus.req_k[1];
        end else begin
            win_cmd.idx = bus.req_idx[IW-1:0];
            win_cmd.j   = bus.req_j[0];
            win_cmd.k   = bus.req_k[0];
        end
    end

    // -------------------------------------------------------------------------
    // Next bank value for the captured command
    // -------------------------------------------------------------------------
    // The per-bit select is a decode against each legal index, so an index
    // at or beyond N (only possible when N is not a power of two) selects
    // nothing and the bank holds.
    logic [N-1:0] sel;
    logic [N-1:0] q_next;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            sel[i]    = (cmd.idx == IW'(i));
            q_next[i] = q_reg[i];
            if (sel[i]) begin
                case ({cmd.j, cmd.k})
                    2'b01:   q_next[i] = 1'b0;
                    2'b10:   q_next[i] = 1'b1;
                    2'b11:   q_next[i] = ~q_reg[i];
                    default: q_next[i] = q_reg[i];
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // A command still in EXEC is dropped: no q change and no done.
            state     <= IDLE;
            cmd       <= '0;
            rr_ptr    <= 1'b0;
            q_reg     <= '0;
            done_reg  <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd    <= win_cmd;
                        // The requester just served loses the next tie.
                        rr_ptr <= ~winner;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    q_reg     <= q_next;
                    done_reg  <= 1'b1;
                    count_reg <= count_reg + 8'd1;   // wraps 255 -> 0
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready = grant;
    assign bus.q         = q_reg;
    assign bus.q1        = ~q_reg;
    assign bus.done      = done_reg;
    assign bus.cmd_count = count_reg;

endmodule
